// File: rtl/ofmaps_bram_reader_pkg.sv
// Shared constants and FSM encoding for the ofmaps BRAM read-back path.
// Also used by the psum adder and the ofmap writer.
package ofmaps_bram_reader_pkg;

  localparam int unsigned DEF_ADDR_WIDTH   = 12;
  localparam int unsigned DEF_OUT_WIDTH    = 8;
  localparam int unsigned DEF_READ_LATENCY = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/ofmaps_bram_reader_if.sv
// Valid/ready beat stream carrying packed ofmap bits with an end-of-transfer marker.
interface ofmaps_bram_reader_if
  import ofmaps_bram_reader_pkg::*;
#(
  parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH
) ();

  logic [OUT_WIDTH-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 m_last;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/ofmaps_bram_reader_read_pipe.sv
// Tracks outstanding BRAM reads so each returning bit lines up with its valid/last tag.
module ofmaps_bram_reader_read_pipe #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      last_q  <= '0;
    end else begin
      valid_q[0] <= in_valid;
      last_q[0]  <= in_valid & in_last;
      for (int i = 1; i < int'(DEPTH); i++) begin
        valid_q[i] <= valid_q[i-1];
        last_q[i]  <= last_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_last  = last_q[DEPTH-1];

endmodule

// File: rtl/ofmaps_bram_reader.sv
// Reads 1-bit ofmap activations from BRAM, packs them LSB-first into beats
// and streams them out with a last marker; backpressure stalls reads, never drops bits.
module ofmaps_bram_reader
  import ofmaps_bram_reader_pkg::*;
#(
  parameter int unsigned OFMAPS_BRAM_ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned OUT_WIDTH              = DEF_OUT_WIDTH,
  parameter int unsigned READ_LATENCY           = DEF_READ_LATENCY
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [OFMAPS_BRAM_ADDR_WIDTH-1:0] base_addr,
  input  logic [OFMAPS_BRAM_ADDR_WIDTH:0]   length,
  output logic                              busy,
  output logic                              done,
  output logic                              bram_en,
  output logic [OFMAPS_BRAM_ADDR_WIDTH-1:0] bram_addr,
  input  logic                              bram_dout,
  ofmaps_bram_reader_if.master              m
);

  localparam int unsigned AW    = OFMAPS_BRAM_ADDR_WIDTH;
  localparam int unsigned LW    = OFMAPS_BRAM_ADDR_WIDTH + 1;
  localparam int unsigned CNT_W = $clog2(OUT_WIDTH);
  localparam int unsigned ISS_W = $clog2(OUT_WIDTH + 1);

  rd_state_e state;
  rd_state_e state_next;

  logic [AW-1:0]        rd_addr;
  logic [LW-1:0]        remaining;
  logic [ISS_W-1:0]     beat_issued;
  logic                 bram_last;

  logic                 cap_valid;
  logic                 cap_last;

  logic [OUT_WIDTH-1:0] pack;
  logic [CNT_W-1:0]     pack_cnt;
  logic                 pack_full;
  logic                 pack_last;

  logic                 issue_c;
  logic                 load_c;
  logic                 done_set_c;
  logic [LW-1:0]        rem_eff_c;
  logic [AW-1:0]        issue_addr_c;
  logic                 out_free_c;
  logic                 pack_done_c;
  logic                 pack_xfer_c;
  logic                 beat_last_c;
  logic [OUT_WIDTH-1:0] pack_word_c;

  ofmaps_bram_reader_read_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_read_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bram_en),
    .in_last   (bram_last),
    .out_valid (cap_valid),
    .out_last  (cap_last)
  );

  // Pack completion and hand-off to the output register
  always_comb begin
    out_free_c  = !m.m_valid || m.m_ready;
    pack_word_c = pack;
    if (cap_valid) begin
      pack_word_c = pack | (OUT_WIDTH'(bram_dout) << pack_cnt);
    end
    pack_done_c = cap_valid && ((pack_cnt == CNT_W'(OUT_WIDTH - 1)) || cap_last);
    pack_xfer_c = (pack_done_c || pack_full) && out_free_c;
    beat_last_c = cap_valid ? cap_last : pack_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A read is only issued when its bit is guaranteed a slot in pack
  always_comb begin
    state_next   = state;
    issue_c      = 1'b0;
    load_c       = 1'b0;
    done_set_c   = 1'b0;
    rem_eff_c    = remaining;
    issue_addr_c = rd_addr;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (length != '0) begin
            load_c       = 1'b1;
            issue_c      = 1'b1;
            rem_eff_c    = length;
            issue_addr_c = base_addr;
            state_next   = (length == LW'(1)) ? ST_DRAIN : ST_READ;
          end else begin
            done_set_c = 1'b1;
          end
        end
      end
      ST_READ: begin
        if ((remaining != '0) &&
            ((beat_issued < ISS_W'(OUT_WIDTH)) || pack_xfer_c)) begin
          issue_c = 1'b1;
          if (remaining == LW'(1)) begin
            state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (m.m_valid && m.m_ready && m.m_last) begin
          state_next = ST_IDLE;
          done_set_c = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Read issue side: address, remaining count and per-beat issue budget
  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      bram_en     <= 1'b0;
      bram_addr   <= '0;
      bram_last   <= 1'b0;
      rd_addr     <= '0;
      remaining   <= '0;
      beat_issued <= '0;
    end else begin
      done      <= done_set_c;
      busy      <= (state_next != ST_IDLE);
      bram_en   <= issue_c;
      bram_last <= issue_c && (rem_eff_c == LW'(1));
      if (issue_c) begin
        bram_addr <= issue_addr_c;
        rd_addr   <= issue_addr_c + AW'(1);
        remaining <= rem_eff_c - LW'(1);
      end
      if (load_c) begin
        beat_issued <= ISS_W'(1);
      end else if (pack_xfer_c) begin
        beat_issued <= ISS_W'(issue_c);
      end else if (issue_c) begin
        beat_issued <= beat_issued + ISS_W'(1);
      end
    end
  end

  // Capture side: pack register and output beat register
  always_ff @(posedge clk) begin
    if (rst) begin
      pack      <= '0;
      pack_cnt  <= '0;
      pack_full <= 1'b0;
      pack_last <= 1'b0;
      m.m_valid <= 1'b0;
      m.m_data  <= '0;
      m.m_last  <= 1'b0;
    end else begin
      if (pack_xfer_c) begin
        pack      <= '0;
        pack_cnt  <= '0;
        pack_full <= 1'b0;
        pack_last <= 1'b0;
      end else if (pack_done_c) begin
        pack      <= pack_word_c;
        pack_full <= 1'b1;
        pack_last <= cap_last;
      end else if (cap_valid) begin
        pack     <= pack_word_c;
        pack_cnt <= pack_cnt + CNT_W'(1);
      end

      if (pack_xfer_c) begin
        m.m_data  <= pack_word_c;
        m.m_last  <= beat_last_c;
        m.m_valid <= 1'b1;
      end else if (m.m_ready) begin
        m.m_valid <= 1'b0;
        m.m_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ofmaps_bram_reader.sv
// Bench for ofmaps_bram_reader: two instances (read latency 1 and 2) share stimulus
// and are checked against a transaction-level model of the expected reads and beats.
module tb_ofmaps_bram_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] base_in;
  logic [12:0] len_in;
  logic        m_ready;

  logic        en     [2];
  logic [11:0] addr   [2];
  logic        dout   [2];
  logic        busy_w [2];
  logic        done_w [2];
  logic        vld    [2];
  logic        lst    [2];
  logic [7:0]  dat    [2];

  ofmaps_bram_reader_if #(.OUT_WIDTH(8)) s0 ();
  ofmaps_bram_reader_if #(.OUT_WIDTH(8)) s1 ();

  assign s0.m_ready = m_ready;
  assign s1.m_ready = m_ready;
  assign vld[0] = s0.m_valid;
  assign vld[1] = s1.m_valid;
  assign lst[0] = s0.m_last;
  assign lst[1] = s1.m_last;
  assign dat[0] = s0.m_data;
  assign dat[1] = s1.m_data;

  ofmaps_bram_reader #(
    .OFMAPS_BRAM_ADDR_WIDTH (12),
    .OUT_WIDTH              (8),
    .READ_LATENCY           (1)
  ) dut_rl1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_in),
    .length    (len_in),
    .busy      (busy_w[0]),
    .done      (done_w[0]),
    .bram_en   (en[0]),
    .bram_addr (addr[0]),
    .bram_dout (dout[0]),
    .m         (s0)
  );

  ofmaps_bram_reader #(
    .OFMAPS_BRAM_ADDR_WIDTH (12),
    .OUT_WIDTH              (8),
    .READ_LATENCY           (2)
  ) dut_rl2 (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_in),
    .length    (len_in),
    .busy      (busy_w[1]),
    .done      (done_w[1]),
    .bram_en   (en[1]),
    .bram_addr (addr[1]),
    .bram_dout (dout[1]),
    .m         (s1)
  );

  always #5 clk = ~clk;

  function automatic logic mem_bit(input logic [11:0] a);
    return a[0] ^ a[3];
  endfunction

  // BRAM models: latency 1 and latency 2
  logic bd1  = 1'b0;
  logic bd2a = 1'b0;
  logic bd2b = 1'b0;
  always @(posedge clk) begin
    if (en[0]) bd1 <= mem_bit(addr[0]);
    if (en[1]) bd2a <= mem_bit(addr[1]);
    bd2b <= bd2a;
  end
  assign dout[0] = bd1;
  assign dout[1] = bd2b;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int          cyc;
  int          lowcnt;
  logic [11:0] addr_q [2][$];
  logic [8:0]  beat_q [2][$];
  int          done_n    [2];
  int          done_cyc  [2];
  int          last_hs   [2];
  int          first_v   [2];
  int          en_late   [2];
  logic        busy1     [2];
  logic        busy_seen [2];
  logic        stall_prev[2];
  logic [8:0]  prev_beat [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    for (int i = 0; i < 2; i++) begin
      addr_q[i].delete();
      beat_q[i].delete();
      done_n[i]     = 0;
      done_cyc[i]   = -1;
      last_hs[i]    = -1;
      first_v[i]    = -1;
      en_late[i]    = 0;
      busy1[i]      = 1'b0;
      busy_seen[i]  = 1'b0;
      stall_prev[i] = 1'b0;
      prev_beat[i]  = '0;
    end
    lowcnt = 0;
  endtask

  // Sample the current cycle of both instances, then advance one clock
  task automatic tick();
    for (int i = 0; i < 2; i++) begin
      if (stall_prev[i]) begin
        chk($sformatf("hold_valid_i%0d", i), 64'(vld[i]), 64'd1);
        chk($sformatf("hold_beat_i%0d", i), 64'({lst[i], dat[i]}), 64'(prev_beat[i]));
      end
      if (en[i]) addr_q[i].push_back(addr[i]);
      if (en[i] && !m_ready && lowcnt >= 19) en_late[i]++;
      if (vld[i] && first_v[i] < 0) first_v[i] = cyc;
      if (vld[i] && m_ready) begin
        beat_q[i].push_back({lst[i], dat[i]});
        last_hs[i] = cyc;
      end
      if (done_w[i]) begin
        done_n[i]++;
        done_cyc[i] = cyc;
        chk($sformatf("busy_low_at_done_i%0d", i), 64'(busy_w[i]), 64'd0);
      end
      if (cyc == 1) busy1[i] = busy_w[i];
      if (busy_w[i]) busy_seen[i] = 1'b1;
      stall_prev[i] = vld[i] && !m_ready;
      prev_beat[i]  = {lst[i], dat[i]};
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_i%0d", tag, i),
          64'({busy_w[i], done_w[i], en[i], addr[i], vld[i], lst[i], dat[i]}), 64'd0);
    end
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low 20 cycles after first beat
  task automatic run_xfer(input logic [11:0] b, input int l, input int mode, input bit timing);
    int nb;
    int errs;
    logic [8:0] e;
    clear_mon();
    base_in = b;
    len_in  = 13'(l);
    m_ready = 1'b1;
    start   = 1'b1;
    cyc     = 0;
    tick();
    start = 1'b0;
    for (int t = 0; t < 8000 && !(done_n[0] > 0 && done_n[1] > 0); t++) begin
      case (mode)
        1: m_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (first_v[0] >= 0 && lowcnt < 20) begin
            m_ready = 1'b0;
            lowcnt++;
          end else begin
            m_ready = 1'b1;
          end
        end
        default: m_ready = 1'b1;
      endcase
      if (mode == 2 && cyc == 5) begin
        start   = 1'b1;
        base_in = 12'h123;
        len_in  = 13'd5;
      end else begin
        start   = 1'b0;
        base_in = b;
        len_in  = 13'(l);
      end
      tick();
    end
    start = 1'b0;
    chk("done_before_timeout", 64'(done_n[0] > 0 && done_n[1] > 0), 64'd1);
    m_ready = 1'b1;
    repeat (4) tick();

    nb = (l + 7) / 8;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("n_reads_i%0d", i), 64'(addr_q[i].size()), 64'(l));
      errs = 0;
      for (int k = 0; k < addr_q[i].size(); k++) begin
        if (addr_q[i][k] !== 12'(int'(b) + k)) errs++;
      end
      chk($sformatf("read_addr_errs_i%0d", i), 64'(errs), 64'd0);
      chk($sformatf("n_beats_i%0d", i), 64'(beat_q[i].size()), 64'(nb));
      for (int j = 0; j < nb && j < beat_q[i].size(); j++) begin
        e = '0;
        for (int k = 0; k < 8; k++) begin
          if (j * 8 + k < l) e[k] = mem_bit(12'(int'(b) + j * 8 + k));
        end
        e[8] = (j == nb - 1);
        chk($sformatf("beat%0d_i%0d", j, i), 64'(beat_q[i][j]), 64'(e));
      end
      chk($sformatf("done_pulses_i%0d", i), 64'(done_n[i]), 64'd1);
      if (l == 0) begin
        chk($sformatf("len0_done_cycle_i%0d", i), 64'(done_cyc[i]), 64'd1);
        chk($sformatf("len0_busy_seen_i%0d", i), 64'(busy_seen[i]), 64'd0);
      end else begin
        chk($sformatf("done_after_last_i%0d", i), 64'(done_cyc[i]), 64'(last_hs[i] + 1));
        chk($sformatf("busy_cycle1_i%0d", i), 64'(busy1[i]), 64'd1);
      end
      if (timing) chk($sformatf("first_valid_cycle_i%0d", i), 64'(first_v[i]), 64'(10 + i));
      if (mode == 2) chk($sformatf("reads_during_stall_i%0d", i), 64'(en_late[i]), 64'd0);
    end
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    base_in = '0;
    len_in  = '0;
    m_ready = 1'b1;
    cyc     = 0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset_outputs");
    rst = 1'b0;

    run_xfer(12'hAB2, 16, 0, 1'b1);
    run_xfer(12'h000, 3, 0, 1'b0);
    run_xfer(12'(($urandom)), 0, 0, 1'b0);
    run_xfer(12'h7F5, 32, 2, 1'b0);
    run_xfer(12'hFFC, 8, 0, 1'b0);
    run_xfer(12'h3A7, 1, 0, 1'b0);

    // Abort a long transfer with reset mid-read
    clear_mon();
    base_in = 12'h400;
    len_in  = 13'd64;
    m_ready = 1'b1;
    start   = 1'b1;
    cyc     = 0;
    tick();
    start = 1'b0;
    repeat (12) tick();
    chk("busy_before_abort_i0", 64'(busy_w[0]), 64'd1);
    chk("busy_before_abort_i1", 64'(busy_w[1]), 64'd1);
    rst = 1'b1;
    tick();
    chk_zero("abort_outputs");
    rst = 1'b0;
    clear_mon();
    repeat (20) tick();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("abort_no_done_i%0d", i), 64'(done_n[i]), 64'd0);
      chk($sformatf("abort_no_reads_i%0d", i), 64'(addr_q[i].size()), 64'd0);
      chk($sformatf("abort_no_beats_i%0d", i), 64'(beat_q[i].size()), 64'd0);
    end

    run_xfer(12'hAB2, 16, 0, 1'b1);
    run_xfer(12'(($urandom)), 4096, 0, 1'b0);
    for (int r = 0; r < 6; r++) begin
      run_xfer(12'(($urandom)), int'($urandom_range(1, 40)), 1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
